// File: rtl/matmul_ctrl_if.sv
// APB slave bus bundle for the matrix-multiply controller.
interface matmul_ctrl_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                   psel_i;
  logic                   penable_i;
  logic                   pwrite_i;
  logic [BUS_WIDTH/8-1:0] pstrb_i;
  logic [BUS_WIDTH-1:0]   pwdata_i;
  logic [ADDR_WIDTH-1:0]  paddr_i;
  logic                   pready_o;
  logic                   pslverr_o;
  logic [BUS_WIDTH-1:0]   prdata_o;

  // Controller side of the bus.
  modport slave (
    input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
    output pready_o, pslverr_o, prdata_o
  );

  // Bus-master side (CPU bridge or testbench).
  modport master (
    output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
    input  pready_o, pslverr_o, prdata_o
  );
endinterface

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: APB register block plus an FSM that clears the
// systolic engine, feeds K operand slices, waits out the array skew and then
// writes back N result rows.
//
// Engine handshakes (feed and writeback) use strict valid/ready: a transfer
// happens on a rising edge where valid and ready are both high; once valid is
// raised, valid and its payload (k or row) stay fixed until that transfer or
// until an abort/reset returns the FSM to IDLE.
module matmul_ctrl #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  matmul_ctrl_if.slave      apb,
  output logic              busy_o,
  output logic              feed_valid_o,
  input  logic              feed_ready_i,
  output logic [1:0]        feed_k_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [1:0]        wb_row_o,
  output logic              eng_clear_o,
  output logic [2:0]        state_o
);

  // Drain counter must hold N+M-2 for the largest dimensions.
  localparam int DRAIN_W = $clog2(2 * MAX_DIM);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CYCLES  = ADDR_WIDTH'(8'h08);

  logic [2:0]         state;
  logic [1:0]         n_m1;
  logic [1:0]         k_m1;
  logic [1:0]         m_m1;
  logic [1:0]         k_cnt;
  logic [1:0]         row_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [15:0]        cyc_cnt;
  logic [15:0]        cycles_reg;
  logic               done_flag;
  logic               aborted_flag;

  logic busy;
  logic acc;
  logic hit_ctrl;
  logic hit_status;
  logic hit_cycles;
  logic start_bit;
  logic abort_bit;
  logic acc_err;
  logic ctrl_wr;
  logic start_acc;
  logic abort_acc;
  logic status_w1c;
  logic [BUS_WIDTH-1:0] rdata;
  logic unused_bits;

  assign busy = (state != S_IDLE);

  // Bus decode. Unaligned addresses never match an aligned register and so
  // fall into the unmapped error case.
  assign acc        = apb.psel_i & apb.penable_i;
  assign hit_ctrl   = (apb.paddr_i == ADDR_CONTROL);
  assign hit_status = (apb.paddr_i == ADDR_STATUS);
  assign hit_cycles = (apb.paddr_i == ADDR_CYCLES);
  assign start_bit  = apb.pstrb_i[0] & apb.pwdata_i[0];
  assign abort_bit  = apb.pstrb_i[0] & apb.pwdata_i[7];

  // START while busy is an error unless ABORT rides along, in which case the
  // write is a legal abort (ABORT wins).
  assign acc_err = ~(hit_ctrl | hit_status | hit_cycles)
                 | (apb.pwrite_i & hit_cycles)
                 | (apb.pwrite_i & hit_ctrl & start_bit & ~abort_bit & busy);

  assign ctrl_wr    = acc & apb.pwrite_i & hit_ctrl & apb.pstrb_i[0] & ~acc_err;
  assign start_acc  = ctrl_wr & apb.pwdata_i[0] & ~busy;
  assign abort_acc  = ctrl_wr & apb.pwdata_i[7] & busy;
  assign status_w1c = acc & apb.pwrite_i & hit_status & apb.pstrb_i[0] & ~acc_err;

  // Only byte 0 of the write data and strobes carries meaning.
  assign unused_bits = ^{apb.pwdata_i[BUS_WIDTH-1:8], apb.pstrb_i[BUS_WIDTH/8-1:1]};

  // Read mux: data only during a good read access, zero otherwise.
  always_comb begin
    rdata = '0;
    if (acc && !apb.pwrite_i && !acc_err) begin
      if (hit_ctrl) begin
        rdata = BUS_WIDTH'({m_m1, k_m1, n_m1, 1'b0});
      end else if (hit_status) begin
        rdata = BUS_WIDTH'({aborted_flag, done_flag, busy});
      end else if (hit_cycles) begin
        rdata = BUS_WIDTH'(cycles_reg);
      end
    end
  end

  assign apb.pready_o  = acc;
  assign apb.pslverr_o = acc & acc_err;
  assign apb.prdata_o  = rdata;

  assign busy_o       = busy;
  assign eng_clear_o  = (state == S_CLEAR);
  assign feed_valid_o = (state == S_FEED);
  assign feed_k_o     = k_cnt;
  assign wb_valid_o   = (state == S_WB);
  assign wb_row_o     = row_cnt;
  assign state_o      = state;

  // Dimension fields: writable only while idle so a running job never sees
  // its shape change underneath it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_m1 <= '0;
      k_m1 <= '0;
      m_m1 <= '0;
    end else if (ctrl_wr && !busy) begin
      n_m1 <= apb.pwdata_i[2:1];
      k_m1 <= apb.pwdata_i[4:3];
      m_m1 <= apb.pwdata_i[6:5];
    end
  end

  // Sequencer FSM with its k/row/drain counters and the operation cycle count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            state   <= S_CLEAR;
            k_cnt   <= '0;
            row_cnt <= '0;
            cyc_cnt <= 16'd1;
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
        end
        S_FEED: begin
          if (feed_ready_i) begin
            if (k_cnt == k_m1) begin
              state     <= S_DRAIN;
              // N+M-1 drain cycles, counted down to zero inclusive.
              drain_cnt <= DRAIN_W'(n_m1) + DRAIN_W'(m_m1);
            end else begin
              k_cnt <= k_cnt + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_WB;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_WB: begin
          if (wb_ready_i) begin
            if (row_cnt == n_m1) begin
              state <= S_DONE;
            end else begin
              row_cnt <= row_cnt + 2'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Count every busy cycle up to and including DONE, saturating.
      if (busy && state != S_DONE && cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end

      if (abort_acc) begin
        state <= S_IDLE;
      end
    end
  end

  // Sticky status flags and the completed-operation cycle count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_flag    <= 1'b0;
      aborted_flag <= 1'b0;
      cycles_reg   <= '0;
    end else begin
      if (status_w1c) begin
        if (apb.pwdata_i[1]) done_flag    <= 1'b0;
        if (apb.pwdata_i[2]) aborted_flag <= 1'b0;
      end
      // Setting DONE is placed after the clear so that it wins a collision.
      if (state == S_DONE && !abort_acc) begin
        done_flag  <= 1'b1;
        cycles_reg <= cyc_cnt;
      end
      if (abort_acc) begin
        aborted_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed testbench for matmul_ctrl.
module tb_matmul_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       busy, feed_valid, feed_ready, wb_valid, wb_ready, eng_clear;
  logic [1:0] feed_k, wb_row;
  logic [2:0] state_dbg;

  matmul_ctrl_if #(.BUS_WIDTH(32), .ADDR_WIDTH(16)) apb();

  matmul_ctrl #(.BUS_WIDTH(32), .ADDR_WIDTH(16), .MAX_DIM(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .apb          (apb),
    .busy_o       (busy),
    .feed_valid_o (feed_valid),
    .feed_ready_i (feed_ready),
    .feed_k_o     (feed_k),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_row_o     (wb_row),
    .eng_clear_o  (eng_clear),
    .state_o      (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected sequences and what the monitor saw.
  logic [1:0] exp_q[$];
  logic [1:0] exp_wb_q[$];
  logic [1:0] obs_feed_q[$];
  logic [1:0] obs_wb_q[$];
  int busy_cnt, clear_cnt, drain_cnt, stall_viol;
  bit op_timeout;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic err);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = addr; apb.pwdata_i = data; apb.pstrb_i = strb;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    #1;
    checks++;
    if (apb.pready_o !== 1'b1) begin
      errors++;
      $display("FAIL pready_write: got %b want 1", apb.pready_o);
    end
    err = apb.pslverr_o;
    @(posedge clk); #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] data,
                          output logic err);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = addr; apb.pstrb_i = 4'h0;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    #1;
    checks++;
    if (apb.pready_o !== 1'b1) begin
      errors++;
      $display("FAIL pready_read: got %b want 1", apb.pready_o);
    end
    data = apb.prdata_o;
    err  = apb.pslverr_o;
    @(posedge clk); #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
  endtask

  // Runs from the CLEAR cycle until busy falls, recording engine traffic.
  // Cycle c=1 is CLEAR; in alternating mode ready is high on even cycles.
  task automatic run_op(input bit alt_ready);
    int c;
    bit f_stall, w_stall;
    logic [1:0] f_last, w_last;
    obs_feed_q.delete(); obs_wb_q.delete();
    busy_cnt = 0; clear_cnt = 0; drain_cnt = 0; stall_viol = 0; op_timeout = 0;
    f_stall = 0; w_stall = 0; f_last = '0; w_last = '0; c = 1;
    while (busy === 1'b1) begin
      feed_ready = alt_ready ? (c % 2 == 0) : 1'b1;
      wb_ready   = alt_ready ? (c % 2 == 0) : 1'b1;
      #1;
      busy_cnt++;
      if (eng_clear) clear_cnt++;
      if (f_stall && (feed_valid !== 1'b1 || feed_k !== f_last)) stall_viol++;
      if (w_stall && (wb_valid !== 1'b1 || wb_row !== w_last)) stall_viol++;
      if (feed_valid && feed_ready) obs_feed_q.push_back(feed_k);
      if (wb_valid && wb_ready) obs_wb_q.push_back(wb_row);
      if (!eng_clear && !feed_valid && !wb_valid &&
          obs_feed_q.size() != 0 && obs_wb_q.size() == 0) drain_cnt++;
      f_stall = feed_valid && !feed_ready; f_last = feed_k;
      w_stall = wb_valid && !wb_ready;     w_last = wb_row;
      @(posedge clk); #1;
      c++;
      if (c > 200) begin
        op_timeout = 1;
        break;
      end
    end
    feed_ready = 1'b1;
    wb_ready   = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic e;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    checks++;
    if ({busy, feed_valid, wb_valid, eng_clear} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000", {busy, feed_valid, wb_valid, eng_clear});
    end
    checks++;
    if ({apb.pready_o, apb.pslverr_o, apb.prdata_o} !== 34'h0) begin
      errors++;
      $display("FAIL reset_apb_idle: got %h want 0", {apb.pready_o, apb.pslverr_o, apb.prdata_o});
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_status: got %h/%b want 0/0", d, e); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h want 0", d); end
    apb_read(16'h00, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_control: got %h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d; logic e;
    feed_ready = 1'b1; wb_ready = 1'b1;
    apb_write(16'h00, 32'h01, 4'hF, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b1 || eng_clear !== 1'b1) begin
      errors++;
      $display("FAIL single_start: got err=%b busy=%b clr=%b want 0 1 1", e, busy, eng_clear);
    end
    run_op(1'b0);
    checks++;
    if (op_timeout) begin errors++; $display("FAIL single_timeout: got timeout want completion"); end
    checks++;
    if (busy_cnt != 5 || clear_cnt != 1 || drain_cnt != 1) begin
      errors++;
      $display("FAIL single_timing: got busy=%0d clr=%0d drain=%0d want 5 1 1", busy_cnt, clear_cnt, drain_cnt);
    end
    checks++;
    if (obs_feed_q.size() != 1 || obs_feed_q[0] !== 2'd0 || obs_wb_q.size() != 1 || obs_wb_q[0] !== 2'd0) begin
      errors++;
      $display("FAIL single_xfers: got feeds=%0d wbs=%0d want 1 1 (k0,row0)", obs_feed_q.size(), obs_wb_q.size());
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL single_status: got %h want 2", d); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL single_cycles: got %0d want 5", d); end
    apb_write(16'h04, 32'h2, 4'hF, e);
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_done: got %h want 0", d); end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic e;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_wb_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    apb_write(16'h00, 32'h7F, 4'hF, e);
    run_op(1'b1);
    checks++;
    if (op_timeout || stall_viol != 0) begin
      errors++;
      $display("FAIL stall_hold: got timeout=%b violations=%0d want 0 0", op_timeout, stall_viol);
    end
    checks++;
    if (obs_feed_q.size() != exp_q.size() || obs_wb_q.size() != exp_wb_q.size()) begin
      errors++;
      $display("FAIL stall_counts: got feeds=%0d wbs=%0d want 4 4", obs_feed_q.size(), obs_wb_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_feed_q[i] !== exp_q[i] || obs_wb_q[i] !== exp_wb_q[i]) begin
          errors++;
          $display("FAIL stall_seq[%0d]: got k=%0d row=%0d want %0d %0d", i, obs_feed_q[i], obs_wb_q[i], exp_q[i], exp_wb_q[i]);
        end
      end
    end
    checks++;
    if (drain_cnt != 7 || busy_cnt != 23) begin
      errors++;
      $display("FAIL stall_timing: got drain=%0d busy=%0d want 7 23", drain_cnt, busy_cnt);
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL stall_status: got %h want 2", d); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'd23) begin errors++; $display("FAIL stall_cycles: got %0d want 23", d); end
    apb_write(16'h04, 32'h2, 4'hF, e);
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    feed_ready = 1'b0;
    apb_write(16'h00, 32'h7F, 4'hF, e);
    step(1);
    apb_write(16'h00, 32'h01, 4'hF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_start_busy: got %b want 1", e); end
    checks++;
    if (feed_valid !== 1'b1 || feed_k !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_state_kept: got fv=%b k=%0d busy=%b want 1 0 1", feed_valid, feed_k, busy);
    end
    apb_read(16'h00, d, e);
    checks++;
    if (d !== 32'h7E) begin errors++; $display("FAIL err_dims_kept: got %h want 7e", d); end
    apb_read(16'h0C, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_unmapped: got %b/%h want 1/0", e, d); end
    apb_read(16'h02, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_unaligned: got %b/%h want 1/0", e, d); end
    apb_write(16'h08, 32'h1234, 4'hF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_write_cycles: got %b want 1", e); end
    apb_write(16'h00, 32'h80, 4'hF, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b0 || feed_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_feed: got err=%b busy=%b fv=%b want 0 0 0", e, busy, feed_valid);
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL abort_status: got %h want 4", d); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'd23) begin errors++; $display("FAIL abort_cycles_kept: got %0d want 23", d); end
    apb_write(16'h04, 32'h4, 4'hF, e);
    feed_ready = 1'b1;
    apb_write(16'h00, 32'h01, 4'h0, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL strobe_no_start: got err=%b busy=%b want 0 0", e, busy);
    end
    apb_read(16'h00, d, e);
    checks++;
    if (d !== 32'h7E) begin errors++; $display("FAIL strobe_ctrl_kept: got %h want 7e", d); end
  endtask

  task automatic test_abort_drain();
    logic [31:0] d; logic e;
    feed_ready = 1'b1; wb_ready = 1'b1;
    apb_write(16'h00, 32'h7F, 4'hF, e);
    step(5);
    checks++;
    if (busy !== 1'b1 || feed_valid !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_entered: got busy=%b fv=%b wv=%b want 1 0 0", busy, feed_valid, wb_valid);
    end
    apb_write(16'h00, 32'h80, 4'hF, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_drain: got err=%b busy=%b wv=%b want 0 0 0", e, busy, wb_valid);
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL abort_drain_status: got %h want 4", d); end
    apb_write(16'h04, 32'h4, 4'hF, e);
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_aborted: got %h want 0", d); end
    apb_write(16'h00, 32'h80, 4'hF, e);
    apb_read(16'h04, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL abort_idle_ignored: got %b/%h want 0/0", e, d); end
  endtask

  task automatic test_start_abort_together();
    logic [31:0] d; logic e;
    apb_write(16'h00, 32'h81, 4'hF, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL both_idle_starts: got err=%b busy=%b want 0 1", e, busy); end
    apb_write(16'h00, 32'h81, 4'hF, e);
    checks++;
    if (e !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL both_busy_aborts: got err=%b busy=%b want 0 0", e, busy); end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL both_status: got %h want 4", d); end
    apb_write(16'h04, 32'h4, 4'hF, e);
  endtask

  task automatic test_back_to_back_w1c();
    logic [31:0] d; logic e;
    feed_ready = 1'b1; wb_ready = 1'b1;
    apb_write(16'h00, 32'h01, 4'hF, e);
    step(3);
    // Access cycle of this clear coincides with the DONE state.
    apb_write(16'h04, 32'h2, 4'hF, e);
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL w1c_collision: got %h want 2", d); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL collision_cycles: got %0d want 5", d); end
  endtask

  task automatic test_reset_wb();
    logic [31:0] d; logic e;
    feed_ready = 1'b1; wb_ready = 1'b0;
    apb_write(16'h00, 32'h01, 4'hF, e);
    step(3);
    checks++;
    if (wb_valid !== 1'b1 || wb_row !== 2'd0) begin
      errors++;
      $display("FAIL wb_reached: got wv=%b row=%0d want 1 0", wb_valid, wb_row);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: got wv=%b busy=%b want 0 0", wb_valid, busy);
    end
    apb_read(16'h04, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_status: got %h want 0", d); end
    apb_read(16'h08, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_cycles: got %0d want 0", d); end
    wb_ready = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    feed_ready = 1'b1; wb_ready = 1'b1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.pstrb_i = 4'h0; apb.pwdata_i = 32'h0; apb.paddr_i = 16'h0;
    #1;
    test_reset();
    test_single();
    test_stall();
    test_errors();
    test_abort_drain();
    test_start_abort_together();
    test_back_to_back_w1c();
    test_reset_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-003 SHALL have parameter MAX_DIM, default 4, maximum matrix dimension; dimension fields are 2 bits wide.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have APB slave ports: psel_i, penable_i, pwrite_i (1 each); pstrb_i (BUS_WIDTH/8); pwdata_i (BUS_WIDTH); paddr_i (ADDR_WIDTH) -- all inputs.
REQ-007 SHALL have APB outputs: pready_o (1), pslverr_o (1), prdata_o (BUS_WIDTH).
REQ-008 SHALL have port busy_o  output  1  operation in progress.
REQ-009 SHALL have engine feed handshake: feed_valid_o output 1, feed_ready_i input 1, feed_k_o output 2 (operand index k).
REQ-010 SHALL have engine writeback handshake: wb_valid_o output 1, wb_ready_i input 1, wb_row_o output 2 (result row).
REQ-011 SHALL have port eng_clear_o  output  1  one-cycle accumulator clear pulse.

Function
REQ-012 Register map: 0x00 CONTROL (R/W), 0x04 STATUS (R, W1C), 0x08 CYCLES (R).
REQ-013 CONTROL: bit0 START (self-clearing, reads 0), bits[2:1] N-1, bits[4:3] K-1, bits[6:5] M-1, bit7 ABORT (self-clearing, reads 0).
REQ-014 STATUS: bit0 BUSY, bit1 DONE (sticky), bit2 ABORTED (sticky); writing 1 to bit1/bit2 clears it.
REQ-015 CYCLES: 16-bit count of cycles from leaving IDLE to entering DONE for the last completed operation; saturates at 0xFFFF.
REQ-016 APB zero-wait: pready_o = 1 whenever psel_i & penable_i; write takes effect at end of access cycle; prdata_o valid in access cycle, 0 otherwise.
REQ-017 CONTROL byte 0 updated only when pstrb_i[0] = 1; other bytes ignored.
REQ-018 pslverr_o = 1 in access cycle for: unmapped or unaligned (paddr_i[1:0] != 0) address; write to CYCLES; write to CONTROL with START = 1 while busy. Erroneous access changes no state; read returns 0.
REQ-019 FSM states IDLE, CLEAR, FEED, DRAIN, WB, DONE.
REQ-020 IDLE -> CLEAR on accepted START write; dimensions latched at that edge; busy_o = 1 from the next cycle.
REQ-021 CLEAR: eng_clear_o = 1 for exactly one cycle; -> FEED.
REQ-022 FEED: feed_valid_o = 1, feed_k_o = k starting at 0; k increments on each cycle with feed_valid_o & feed_ready_i; feed_valid_o and feed_k_o held stable while feed_ready_i = 0; after transfer k = K-1 -> DRAIN.
REQ-023 DRAIN: wait exactly N+M-1 cycles (systolic skew) via down-counter; -> WB.
REQ-024 WB: wb_valid_o = 1, wb_row_o = r from 0; r increments per handshake; held stable while stalled; after row N-1 transfers -> DONE.
REQ-025 DONE: one cycle; sets DONE, stores CYCLES; busy_o = 0 from the next cycle; -> IDLE.
REQ-026 ABORT write accepted in any non-IDLE state: -> IDLE next cycle; feed_valid_o/wb_valid_o drop; ABORTED set; DONE and CYCLES unchanged. ABORT in IDLE is ignored, no error.
REQ-027 START and ABORT both set in one write: ABORT wins when busy; when idle, START is accepted.
REQ-028 W1C of DONE in the same cycle DONE is set: set wins.
REQ-029 busy_o equals STATUS.BUSY = (state != IDLE).

Reset
REQ-030 On rst_i = 1 at a clock edge: state IDLE; busy_o, feed_valid_o, wb_valid_o, eng_clear_o, pslverr_o = 0; prdata_o = 0; STATUS = 0; CYCLES = 0; counters and latched dimensions = 0; pready_o follows REQ-016.
REQ-031 Reset asserted mid-operation aborts immediately without setting ABORTED; reset has priority over any APB access in the same cycle.

Verification
REQ-032 Write 0x00 = 0x01 (1x1x1), feed_ready_i = wb_ready_i = 1 -> eng_clear_o 1 cycle, 1 feed (k=0), 1 drain cycle, 1 wb (row 0), DONE = 1, CYCLES = 5, busy_o high for 5 cycles.
REQ-033 Write 0x00 = 0x7F (4x4x4), feed_ready_i low every other cycle -> feed_k_o 0..3 each stable until accepted, 7 drain cycles, wb_row_o 0..3, STATUS reads 0x2.
REQ-034 START during FEED -> pslverr_o = 1, dimensions/state unchanged; read 0x0C -> pslverr_o = 1, prdata_o = 0; write 0x01 with pstrb_i = 0 -> no start.
REQ-035 Write ABORT (0x80) during DRAIN -> IDLE next cycle, STATUS = 0x4; write 0x04 = 0x4 -> STATUS = 0x0.
REQ-036 rst_i pulsed during WB with wb_ready_i = 0 -> next cycle wb_valid_o = 0, busy_o = 0, STATUS = 0, CYCLES = 0.
